shared_reg_arbiter: RTL and testbench

- Shares one WIDTH-bit storage register between NUM_REQ requesters.
- Round-robin arbitration, with an optional lock so one requester can hold ownership for a burst.
- Internally sequences a Register-style storage element through an N-way mux select and a write enable.
- Sits between producer-side Filament components and a single shared state element. Consumers read `out` and `owner`.

---
 rtl/shared_reg_arb_pkg.sv | 22 ++
 rtl/rr_picker.sv | 29 ++
 rtl/shared_reg_arbiter.sv | 110 +++++++++++
 tb/tb_shared_reg_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arb_pkg.sv
// Shared types and helpers for the shared-register arbiter.
package shared_reg_arb_pkg;

  localparam int unsigned MAX_REQ  = 16;
  localparam int unsigned MAX_ID_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Index of the set bit; zero for an all-zero vector.
  function automatic logic [MAX_ID_W-1:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, scanning circularly.
module rr_picker
  import shared_reg_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] scan;

  always_comb begin
    gnt_oh = '0;
    scan   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (req[scan] && (gnt_oh == '0)) gnt_oh[scan] = 1'b1;
    end
  end

  assign idx = ID_W'(onehot_idx(MAX_REQ'(gnt_oh)));
  assign any = |req;

endmodule

// File: rtl/shared_reg_arbiter.sv
// One WIDTH-bit register shared by NUM_REQ writers: round-robin grant with
// an optional per-owner lock that holds ownership across a burst.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned WIDTH   = 32,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [NUM_REQ*WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         out,
  output logic [ID_W-1:0]          owner,
  output logic                     owner_valid,
  output logic                     locked
);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     out_q, out_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;
  logic [NUM_REQ-1:0]   owner_oh;
  logic                 wr_en;
  logic [ID_W-1:0]      wr_idx;
  logic [WIDTH-1:0]     data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = data[g*WIDTH +: WIDTH];
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .ptr    (rr_ptr_q),
    .gnt_oh (pick_gnt),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign owner_oh = NUM_REQ'(1) << owner_q;

  // Grant, next state and storage write-enable / data mux.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    valid_d  = valid_q;
    out_d    = out_q;
    gnt      = '0;
    wr_en    = 1'b0;
    wr_idx   = owner_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt      = pick_gnt;
          wr_en    = 1'b1;
          wr_idx   = pick_idx;
          owner_d  = pick_idx;
          valid_d  = 1'b1;
          rr_ptr_d = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + ID_W'(1);
          if (lock[pick_idx]) state_d = LOCKED;
        end
      end
      LOCKED: begin
        // The final beat still writes when the owner requests while releasing.
        if (req[owner_q]) begin
          gnt   = owner_oh;
          wr_en = 1'b1;
        end
        if (!lock[owner_q]) state_d = IDLE;
      end
    endcase
    if (wr_en) out_d = data_arr[wr_idx];
    if (!reset) gnt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      valid_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
    end
  end

  assign out         = out_q;
  assign owner       = owner_q;
  assign owner_valid = valid_q;
  assign locked      = (state_q == LOCKED);

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));
  a_lock_excl:   assert property (@(posedge clk) disable iff (!reset)
                                  (state_q == LOCKED) |-> ((gnt & ~owner_oh) == '0));

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: immediate-assert checks, expected
// register contents queued at drive time and popped after the write edge.
module tb_shared_reg_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 8;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR-1:0]   lock;
  logic [NR*W-1:0] data;
  logic [NR-1:0]   gnt;
  logic [W-1:0]    out;
  logic [1:0]      owner;
  logic            owner_valid;
  logic            locked;

  typedef struct packed {
    logic [7:0] out;
    logic [1:0] owner;
    logic       valid;
    logic       locked;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_out;
  logic [1:0] m_owner;
  logic       m_valid;
  logic       m_locked;

  shared_reg_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .lock        (lock),
    .data        (data),
    .gnt         (gnt),
    .out         (out),
    .owner       (owner),
    .owner_valid (owner_valid),
    .locked      (locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input exp_t e);
    chk(tag, "out",         32'(out),         32'(e.out));
    chk(tag, "owner",       32'(owner),       32'(e.owner));
    chk(tag, "owner_valid", 32'(owner_valid), 32'(e.valid));
    chk(tag, "locked",      32'(locked),      32'(e.locked));
  endtask

  task automatic model_reset();
    m_out = '0; m_owner = '0; m_valid = 1'b0; m_locked = 1'b0;
    sb.delete();
  endtask

  // One cycle: drive, check the same-cycle grant, queue expected registers, check after the edge.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d,
                      input logic [3:0] eg, input string tag);
    exp_t e;
    int   idx;
    req = r; lock = l; data = d;
    #2;
    chk(tag, "gnt", 32'(gnt), 32'(eg));
    idx = -1;
    for (int i = 0; i < 4; i++) if (eg[i]) idx = i;
    if (m_locked) m_locked = l[m_owner];
    else          m_locked = (idx >= 0) && l[idx];
    if (idx >= 0) begin
      m_out   = d[idx*8 +: 8];
      m_owner = 2'(idx);
      m_valid = 1'b1;
    end
    sb.push_back('{m_out, m_owner, m_valid, m_locked});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_regs(tag, e);
  endtask

  initial begin
    exp_t z;
    z = '0;
    reset = 1'b0; req = '0; lock = '0; data = '0;
    model_reset();

    // Reset holds everything at zero and masks grants even with requests.
    @(posedge clk); #1;
    req = 4'b1111;
    #1;
    chk("rst", "gnt", 32'(gnt), 32'd0);
    chk_regs("rst", z);
    req = '0;
    #1 reset = 1'b1;

    // 1: idle with no requests.
    for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 32'h0, 4'b0000, "t1 idle");

    // 2: all requesting, rotating grants.
    step(4'b1111, 4'b0000, 32'h13121110, 4'b0001, "t2 b0");
    step(4'b1111, 4'b0000, 32'h13121110, 4'b0010, "t2 b1");
    step(4'b1111, 4'b0000, 32'h13121110, 4'b0100, "t2 b2");
    step(4'b1111, 4'b0000, 32'h13121110, 4'b1000, "t2 b3");
    step(4'b1111, 4'b0000, 32'h13121110, 4'b0001, "t2 b4");

    // 3: requester 2 bursts under lock while requester 0 waits.
    step(4'b0101, 4'b0100, 32'h33A02255, 4'b0100, "t3 l0");
    step(4'b0101, 4'b0100, 32'h33A12255, 4'b0100, "t3 l1");
    step(4'b0101, 4'b0100, 32'h33A22255, 4'b0100, "t3 l2");
    step(4'b0001, 4'b0000, 32'h33A32255, 4'b0000, "t3 rel");
    step(4'b0001, 4'b0000, 32'h33A32255, 4'b0001, "t3 wrap");

    // 4: locked owner idles without requesting, then releases.
    step(4'b0010, 4'b0010, 32'h44434241, 4'b0010, "t4 lock");
    step(4'b0000, 4'b0010, 32'h44434241, 4'b0000, "t4 hold0");
    step(4'b0000, 4'b0010, 32'h44434241, 4'b0000, "t4 hold1");
    step(4'b0000, 4'b0000, 32'h44434241, 4'b0000, "t4 rel");

    // 5: asynchronous reset in the middle of a lock.
    step(4'b1000, 4'b1000, 32'hD3D2D1D0, 4'b1000, "t5 lock");
    req = 4'b1000; lock = 4'b1000;
    #2;
    chk("t5 held", "gnt", 32'(gnt), 32'b1000);
    reset = 1'b0;
    #1;
    model_reset();
    chk("t5 async", "gnt", 32'(gnt), 32'd0);
    chk_regs("t5 async", z);
    @(posedge clk); #1;
    chk_regs("t5 inrst", z);
    lock = 4'b0000;
    #2 reset = 1'b1;
    #1;
    chk("t5 post", "gnt", 32'(gnt), 32'b1000);
    m_out = 8'hD3; m_owner = 2'd3; m_valid = 1'b1;
    sb.push_back('{m_out, m_owner, m_valid, m_locked});
    @(posedge clk); #1;
    chk_regs("t5 post", sb.pop_front());

    // 6: circular wrap from ptr 3; a lock from a non-winner is ignored.
    step(4'b0100, 4'b0000, 32'h63626160, 4'b0100, "t6 ptr3");
    step(4'b0101, 4'b0100, 32'h63626160, 4'b0001, "t6 wrap");
    step(4'b0101, 4'b0000, 32'h63626160, 4'b0100, "t6 next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
